// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter that shares one external ALU between two
// requesters. Each operation walks IDLE -> EXEC -> DONE -> IDLE, so there is at
// most one operation every three cycles.
//
// Handshake: a requester raises reqN and holds it, together with stable
// operands, until it is granted. Operands are copied into SrcA/SrcB/ULAControl
// on the grant edge, so later changes to aN/bN/ctlN do not affect that
// operation. ackN is a one-cycle pulse in DONE, and result/zero/err are valid
// from that cycle on. A req still high in the IDLE cycle after its ack counts
// as a new request. Dropping req during EXEC or DONE does not cancel the
// operation that is already running.
module ula_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [2:0] ctl0,
    input  logic [2:0] ctl1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] result,
    output logic       zero,
    output logic       err,
    output logic       busy,
    output logic [7:0] SrcA,
    output logic [7:0] SrcB,
    output logic [2:0] ULAControl,
    input  logic [7:0] ULAResult,
    input  logic       Z,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    logic   ptr;    // requester that wins when both ask at once
    logic   gnt;    // requester that owns the operation in flight
    logic   pick;   // requester that would win a grant this cycle
    logic   load;   // grant strobe: copy the winner's operands
    logic   exec;   // capture strobe: latch the ALU outputs

    // If only one requester is asking, it wins. On a tie, the pointer decides.
    assign pick      = (req0 && req1) ? ptr : req1;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic and the grant/capture strobes.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        exec    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    load    = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                exec    = 1'b1;
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand load on grant, result capture and ack generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 1'b0;
            gnt        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            result     <= 8'h00;
            zero       <= 1'b1;
            err        <= 1'b0;
            SrcA       <= 8'h00;
            SrcB       <= 8'h00;
            ULAControl <= 3'b000;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (load) begin
                gnt        <= pick;
                ptr        <= ~pick;
                SrcA       <= pick ? a1 : a0;
                SrcB       <= pick ? b1 : b0;
                ULAControl <= pick ? ctl1 : ctl0;
            end
            if (exec) begin
                result <= ULAResult;
                zero   <= Z;
                err    <= (ULAControl >= 3'b110);
                ack0   <= ~gnt;
                ack1   <= gnt;
            end
        end
    end

endmodule
